// File: rtl/rv32i_register_file.sv
// RV32I integer register file: two combinational read ports, one synchronous write port.
// x0 is hardwired to zero; asynchronous active-low reset clears every register.
module rv32i_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] reg1_addr,
  input  logic [ADDR_WIDTH-1:0] reg2_addr,
  input  logic [ADDR_WIDTH-1:0] regw_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_ena,
  output logic [DATA_WIDTH-1:0] reg1_data,
  output logic [DATA_WIDTH-1:0] reg2_data
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en;

  // Writes to x0 are dropped here, so entry 0 only ever holds its reset value.
  assign wr_en = write_ena && (regw_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (wr_en) begin
      regs_q[regw_addr] <= write_data;
    end
  end

  // No write-to-read bypass: forwarding is the pipeline's job.
  always_comb begin
    reg1_data = '0;
    if (reg1_addr != '0) begin
      reg1_data = regs_q[reg1_addr];
    end
  end

  always_comb begin
    reg2_data = '0;
    if (reg2_addr != '0) begin
      reg2_data = regs_q[reg2_addr];
    end
  end

endmodule

// File: tb/tb_rv32i_register_file.sv
// Directed bench for rv32i_register_file; stimulus queues expected read values,
// a monitor pops and compares them when a sample strobe fires.
module tb_rv32i_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  reg1_addr;
  logic [4:0]  reg2_addr;
  logic [4:0]  regw_addr;
  logic [31:0] write_data;
  logic        write_ena;
  logic [31:0] reg1_data;
  logic [31:0] reg2_data;

  rv32i_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .NUM_REGS  (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg1_addr (reg1_addr),
    .reg2_addr (reg2_addr),
    .regw_addr (regw_addr),
    .write_data(write_data),
    .write_ena (write_ena),
    .reg1_data (reg1_data),
    .reg2_data (reg2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic chk_stb = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // Monitor: each strobe means the outputs are settled and one expectation is due.
  always @(posedge chk_stb) begin
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: strobe with no expectation queued");
    end else begin
      mon_e = sb_q.pop_front();
      checks += 2;
      if (reg1_data !== mon_e.e1) begin
        errors++;
        $display("FAIL %s port1: got %h expected %h", mon_e.name, reg1_data, mon_e.e1);
      end
      if (reg2_data !== mon_e.e2) begin
        errors++;
        $display("FAIL %s port2: got %h expected %h", mon_e.name, reg2_data, mon_e.e2);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    #1;
    sb_q.push_back(e);
    chk_stb = 1'b1;
    #1;
    chk_stb = 1'b0;
  endtask

  // One write on the next rising edge; enable drops just after it.
  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    regw_addr  = addr;
    write_data = data;
    write_ena  = 1'b1;
    @(posedge clk);
    #1;
    write_ena = 1'b0;
  endtask

  function automatic logic [31:0] sweep_val(input int a);
    return (a == 0) ? 32'h0 : 32'(a) * 32'h01010101;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    reg1_addr  = '0;
    reg2_addr  = '0;
    regw_addr  = '0;
    write_data = '0;
    write_ena  = 1'b0;
    #12;
    rst_n = 1'b1;

    // Reset state on every address.
    for (int i = 0; i < 32; i++) begin
      reg1_addr = 5'(i);
      reg2_addr = 5'(31 - i);
      check("reset_sweep", 32'h0, 32'h0);
    end

    // Mid-cycle reset pulse clears previously written registers without a clock edge.
    write_reg(5'd4, 32'hCAFEF00D);
    write_reg(5'd9, 32'h0BADF00D);
    reg1_addr = 5'd4;
    reg2_addr = 5'd9;
    check("pre_pulse", 32'hCAFEF00D, 32'h0BADF00D);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    check("during_pulse", 32'h0, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      reg1_addr = 5'(i);
      reg2_addr = 5'(31 - i);
      check("pulse_sweep", 32'h0, 32'h0);
    end

    // A write pending while reset is held across the edge is lost.
    @(negedge clk);
    regw_addr  = 5'd6;
    write_data = 32'h66666666;
    write_ena  = 1'b1;
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    write_ena = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    reg1_addr = 5'd6;
    reg2_addr = 5'd6;
    check("write_in_reset", 32'h0, 32'h0);

    // Write then read, each port changing only at its own capturing edge.
    reg1_addr = 5'd1;
    reg2_addr = 5'd2;
    @(negedge clk);
    regw_addr  = 5'd1;
    write_data = 32'h0000FFFF;
    write_ena  = 1'b1;
    check("pre_x1", 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("post_x1", 32'h0000FFFF, 32'h0);
    @(negedge clk);
    regw_addr  = 5'd2;
    write_data = 32'hFFFF0000;
    check("pre_x2", 32'h0000FFFF, 32'h0);
    @(posedge clk);
    #1;
    check("post_x2", 32'h0000FFFF, 32'hFFFF0000);
    @(negedge clk);
    write_ena = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_x1_x2", 32'h0000FFFF, 32'hFFFF0000);

    // x0 protection.
    write_reg(5'd0, 32'hDEADBEEF);
    reg1_addr = 5'd0;
    reg2_addr = 5'd0;
    check("x0_write", 32'h0, 32'h0);

    // Write enable gating.
    write_reg(5'd5, 32'h12345678);
    @(negedge clk);
    regw_addr  = 5'd5;
    write_data = 32'hAAAAAAAA;
    write_ena  = 1'b0;
    repeat (3) @(negedge clk);
    reg1_addr = 5'd5;
    reg2_addr = 5'd1;
    check("ena_gating", 32'h12345678, 32'h0000FFFF);

    // Read during write: old value before the edge, new value after.
    write_reg(5'd3, 32'h11111111);
    reg1_addr = 5'd3;
    reg2_addr = 5'd3;
    @(negedge clk);
    regw_addr  = 5'd3;
    write_data = 32'h22222222;
    write_ena  = 1'b1;
    check("rdw_before", 32'h11111111, 32'h11111111);
    @(posedge clk);
    #1;
    write_ena = 1'b0;
    check("rdw_after", 32'h22222222, 32'h22222222);

    // Back-to-back writes to the same register: last one wins.
    write_reg(5'd8, 32'h00000001);
    write_reg(5'd8, 32'h00000002);
    reg1_addr = 5'd8;
    reg2_addr = 5'd3;
    check("same_reg_b2b", 32'h00000002, 32'h22222222);

    // Full sweep on back-to-back edges.
    for (int a = 1; a < 32; a++) begin
      write_reg(5'(a), sweep_val(a));
    end
    for (int a = 0; a < 32; a++) begin
      reg1_addr = 5'(a);
      reg2_addr = 5'(a);
      check("full_sweep", sweep_val(a), sweep_val(a));
    end

    // Mid-operation reset, then a single write after release.
    @(negedge clk);
    #1;
    rst_n     = 1'b0;
    reg1_addr = 5'd31;
    reg2_addr = 5'd17;
    check("mid_op_reset", 32'h0, 32'h0);
    rst_n = 1'b1;
    write_reg(5'd7, 32'h00000007);
    for (int a = 0; a < 32; a++) begin
      reg1_addr = 5'(a);
      reg2_addr = 5'(31 - a);
      check("post_reset_x7", (a == 7) ? 32'h7 : 32'h0, ((31 - a) == 7) ? 32'h7 : 32'h0);
    end

    #5;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
